// File: rtl/cpu_step_ctrl_pkg.sv
// Shared CPU package: state encoding, default strobe divider
// and a clog2 helper that never returns a zero width.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int DIV_DEFAULT = 8;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_tick.sv
// Wrap counter for the RUN-mode strobe period.
// tick marks the terminal count while counting is enabled.
module tick_gen
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = clog2_min1(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + W'(1);
        end
    end

    assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: periodic strobes in RUN,
// single strobes per step edge in IDLE, sticky HALTED.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_run,
    input  logic             step_req,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_e state;
    logic   step_q;
    logic   step_rise;
    logic   tick;
    logic   tick_clr;
    logic   tick_en;

    assign step_rise = step_req && !step_q;
    assign tick_en   = (state == ST_RUN);
    // Leaving RUN or halting resets the phase so re-entry starts at zero
    assign tick_clr  = (state != ST_RUN) || !mode_run || halt;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_q    <= 1'b0;
            cpu_en    <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            step_q <= step_req;
            cpu_en <= 1'b0;
            if (halt) begin
                state   <= ST_HALTED;
                running <= 1'b0;
                halted  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (mode_run) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end else if (step_rise) begin
                            cpu_en <= 1'b1;
                            if (cycle_cnt != '1)
                                cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!mode_run) begin
                            state   <= ST_IDLE;
                            running <= 1'b0;
                        end else if (tick) begin
                            cpu_en <= 1'b1;
                            if (cycle_cnt != '1)
                                cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                    ST_HALTED: begin
                        state <= ST_HALTED;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        halted  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
